clk_en_synth: RTL and testbench
===============================

CLK_EN_SYNTH -- requirements
Module: clk_en_synth

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent clock-enable channels, legal range 1..8.
REQ-002 Parameter ACC_W, default 32: phase-accumulator width per channel, legal range 8..48.
REQ-003 Parameter LOCK_CYCLES, default 1024: stable cycles after a load before locked asserts, legal range 1..65535.
REQ-004 refclk  input  1  single master clock; all logic SHALL be synchronous to its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load  input  1  one-cycle strobe that captures incr_in and phase-aligns all channels.
REQ-007 incr_in  input  NUM_CH*ACC_W  per-channel increment; channel k uses bits [k*ACC_W +: ACC_W]; increment = f_out/f_refclk * 2^ACC_W.
REQ-008 ch_en  input  NUM_CH  per-channel run enable.
REQ-009 ce  output  NUM_CH  per-channel one-refclk-cycle enable pulse, asserted on accumulator carry-out.
REQ-010 clk_lvl  output  NUM_CH  per-channel square wave equal to accumulator MSB, duty about 50%.
REQ-011 locked  output  1  high when configuration is stable and outputs are valid.

Function
REQ-012 Each channel SHALL hold an ACC_W-bit accumulator acc and an ACC_W-bit registered increment incr_q.
REQ-013 On an edge with load=1 (and rst=0), every incr_q SHALL take its incr_in slice, every acc SHALL clear to 0, and all ce SHALL be 0.
REQ-014 On an edge with load=0, ch_en[k]=1: acc[k] SHALL become (acc[k]+incr_q[k]) mod 2^ACC_W, and ce[k] SHALL become the carry-out of that addition.
REQ-015 On an edge with load=0, ch_en[k]=0: acc[k] SHALL hold and ce[k] SHALL be 0.
REQ-016 ce and clk_lvl SHALL be registered; clk_lvl[k] SHALL equal acc[k][ACC_W-1] as a register output.
REQ-017 incr_q[k]=0 SHALL produce no ce[k] pulses and a constant clk_lvl[k].
REQ-018 Over N enabled cycles after a load, the ce[k] pulse count SHALL be floor(N*incr_q[k]/2^ACC_W), exact with no drift.
REQ-019 Channels with integer-multiple increments SHALL have coincident ce pulses: every pulse of the slower channel coincides with a pulse of the faster one.
REQ-020 A lock counter SHALL clear on load and otherwise increment each cycle, saturating at LOCK_CYCLES.
REQ-021 locked SHALL be 1 only when at least one load has occurred since reset and the lock counter equals LOCK_CYCLES.
REQ-022 A load while locked=1 SHALL drive locked to 0 on the same edge; locked re-asserts LOCK_CYCLES cycles later.
REQ-023 ch_en SHALL NOT affect the lock counter.
REQ-024 Simultaneous rst and load: rst SHALL win.
REQ-025 Back-to-back loads: each load SHALL re-clear acc and the counter; the last captured incr_in takes effect.

Reset
REQ-026 On an edge with rst=1: acc=0, incr_q=0, ce=0, clk_lvl=0, lock counter=0, loaded flag=0, locked=0.
REQ-027 rst asserted mid-operation SHALL force the REQ-026 state on that edge; outputs stay idle until the next load.

Verification
REQ-028 Params ACC_W=8, NUM_CH=3, LOCK_CYCLES=16. Stimulus: load incr 0x80/0x40/0x20, ch_en=111. Response: first ce[0] two cycles after the load edge, then every 2 cycles; ce[1] every 4; ce[2] every 8; all pulses coincident per REQ-019.
REQ-029 Stimulus: load incr 0x60 on channel 0 and run 80 cycles. Response: exactly 30 ce[0] pulses, spaced 3,3,2 repeating; clk_lvl[0] toggles consistently with acc MSB.
REQ-030 Stimulus: load, wait 16 cycles (locked=1), load again. Response: locked=0 on the edge of the second load, then locked=1 exactly 16 cycles later; no locked=1 before the first load after reset.
REQ-031 Stimulus: deassert ch_en[1] for 5 cycles mid-run. Response: ce[1]=0 and acc[1] frozen; the pulse sequence resumes from the held phase; locked unaffected.
REQ-032 Stimulus: rst=1 and load=1 on the same edge while running. Response: all outputs 0 and incr_q=0; no ce pulses afterwards until a new load.
REQ-033 Stimulus: incr 0x00 on channel 2 with incr 0xFF on channel 0. Response: ce[2] never asserts; ce[0] asserts 255 of every 256 cycles.

Source files
------------

// File: rtl/clk_en_synth.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_synth
// Description : Multi-channel phase-accumulator clock-enable generator with a
//               shared load strobe for phase alignment and a lock indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_synth #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [NUM_CH*ACC_W-1:0] incr_in,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       clk_lvl,
    output logic                    locked
);

    localparam int                c_cnt_w    = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_lock_max = c_cnt_w'(LOCK_CYCLES);

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k = k + 1) begin : g_ch
            logic [ACC_W-1:0] r_acc;
            logic [ACC_W-1:0] r_incr_q;
            logic             r_ce;
            logic [ACC_W:0]   w_sum;

            // The extra top bit of the sum is the carry that becomes the pulse.
            assign w_sum = {1'b0, r_acc} + {1'b0, r_incr_q};

            always_ff @(posedge refclk) begin
                if (rst) begin
                    r_acc    <= '0;
                    r_incr_q <= '0;
                    r_ce     <= 1'b0;
                end else if (load) begin
                    r_acc    <= '0;
                    r_incr_q <= incr_in[k*ACC_W +: ACC_W];
                    r_ce     <= 1'b0;
                end else if (ch_en[k]) begin
                    r_acc    <= w_sum[ACC_W-1:0];
                    r_ce     <= w_sum[ACC_W];
                end else begin
                    r_ce     <= 1'b0;
                end
            end

            assign ce[k]      = r_ce;
            assign clk_lvl[k] = r_acc[ACC_W-1];
        end
    endgenerate

    logic [c_cnt_w-1:0] r_lock_cnt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               r_loaded;
    logic               r_locked;

    assign w_cnt_inc = (r_lock_cnt == c_lock_max) ? r_lock_cnt
                                                  : r_lock_cnt + c_cnt_w'(1);

    // Lock is computed from next-state values so a load drops it on the same edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_cnt <= '0;
            r_loaded   <= 1'b0;
            r_locked   <= 1'b0;
        end else if (load) begin
            r_lock_cnt <= '0;
            r_loaded   <= 1'b1;
            r_locked   <= 1'b0;
        end else begin
            r_lock_cnt <= w_cnt_inc;
            r_locked   <= r_loaded && (w_cnt_inc == c_lock_max);
        end
    end

    assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_synth.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_clk_en_synth
// Description : Directed plus randomized bench for clk_en_synth against a
//               closed-form pulse-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_en_synth;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [23:0] incr_in;
    logic [2:0]  ch_en;
    logic [2:0]  ce;
    logic [2:0]  clk_lvl;
    logic        locked;

    int tests = 0;
    int fails = 0;

    // Model: per channel, enabled-cycle count n since load; acc = n*inc mod 256,
    // pulses so far = floor(n*inc/256).
    longint m_inc[3];
    longint m_n[3];
    bit     m_ce[3];
    bit     m_loaded;
    int     m_cnt;

    clk_en_synth #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk  (clk),
        .rst     (rst),
        .load    (load),
        .incr_in (incr_in),
        .ch_en   (ch_en),
        .ce      (ce),
        .clk_lvl (clk_lvl),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [23:0] inc, input logic [2:0] en);
        rst     = r;
        load    = l;
        incr_in = inc;
        ch_en   = en;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                m_inc[k] = 0; m_n[k] = 0; m_ce[k] = 0;
            end
            m_loaded = 0;
            m_cnt    = 0;
        end else if (l) begin
            for (int k = 0; k < 3; k++) begin
                m_inc[k] = longint'((inc >> (8 * k)) & 24'hFF);
                m_n[k]   = 0;
                m_ce[k]  = 0;
            end
            m_loaded = 1;
            m_cnt    = 0;
        end else begin
            m_cnt = (m_cnt < LOCK_CYCLES) ? m_cnt + 1 : LOCK_CYCLES;
            for (int k = 0; k < 3; k++) begin
                if (en[k]) begin
                    m_ce[k] = (((m_n[k] + 1) * m_inc[k]) >> 8) != ((m_n[k] * m_inc[k]) >> 8);
                    m_n[k]++;
                end else begin
                    m_ce[k] = 0;
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ce[%0d]", k), 32'(ce[k]), 32'(m_ce[k]));
            check($sformatf("clk_lvl[%0d]", k), 32'(clk_lvl[k]),
                  32'(((m_n[k] * m_inc[k]) % 256) >= 128));
        end
        check("locked", 32'(locked), 32'(m_loaded && (m_cnt == LOCK_CYCLES)));
    endtask

    initial begin
        int pulses;
        int pulses2;
        int prev;
        rst = 1'b1; load = 1'b0; incr_in = '0; ch_en = '0;

        // Reset, then free-run with no load: lock must stay low
        repeat (3) step(1, 0, 24'h0, 3'b000);
        check("reset_ce", 32'(ce), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);
        repeat (20) step(0, 0, 24'h0, 3'b111);
        check("no_lock_before_load", 32'(locked), 32'h0);

        // Octave increments 0x80/0x40/0x20: coincident pulses
        step(0, 1, 24'h204080, 3'b111);
        step(0, 0, 24'h0, 3'b111);
        check("first_ce0_not_yet", 32'(ce[0]), 32'h0);
        step(0, 0, 24'h0, 3'b111);
        check("first_ce0", 32'(ce[0]), 32'h1);
        repeat (24) begin
            step(0, 0, 24'h0, 3'b111);
            if (ce[2]) check("coinc_ce2", 32'(ce[1:0]), 32'h3);
            if (ce[1]) check("coinc_ce1", 32'(ce[0]), 32'h1);
        end
        check("locked_after_run", 32'(locked), 32'h1);

        // Reload while locked: drops on that edge, returns after 16 cycles
        step(0, 1, 24'h204080, 3'b111);
        check("unlock_on_load", 32'(locked), 32'h0);
        for (int i = 1; i <= LOCK_CYCLES; i++) begin
            step(0, 0, 24'h0, 3'b111);
            check("relock_timing", 32'(locked), 32'(i == LOCK_CYCLES));
        end

        // Fractional increment 0x60: 30 pulses in 80 cycles, spacing 3,3,2
        step(0, 1, {8'($urandom), 8'($urandom), 8'h60}, 3'b111);
        pulses = 0; prev = 0;
        for (int i = 1; i <= 80; i++) begin
            step(0, 0, 24'h0, 3'b111);
            if (ce[0]) begin
                pulses++;
                check("spacing_0x60", 32'(i - prev), (pulses % 3 == 0) ? 32'd2 : 32'd3);
                prev = i;
            end
        end
        check("count_0x60", 32'(pulses), 32'd30);

        // Pause channel 1 for 5 cycles mid-run
        step(0, 1, 24'h305070, 3'b111);
        repeat (10) step(0, 0, 24'h0, 3'b111);
        repeat (5) begin
            step(0, 0, 24'h0, 3'b101);
            check("paused_ce1", 32'(ce[1]), 32'h0);
        end
        repeat (20) step(0, 0, 24'h0, 3'b111);

        // rst and load together: reset wins, no pulses until next load
        step(1, 1, 24'hFFFFFF, 3'b111);
        check("rst_wins_out", 32'({ce, clk_lvl, locked}), 32'h0);
        repeat (10) begin
            step(0, 0, 24'hFFFFFF, 3'b111);
            check("idle_after_rst", 32'({ce, clk_lvl}), 32'h0);
        end

        // Extremes: 0xFF pulses 255 of 256 cycles, 0x00 never pulses
        step(0, 1, {8'h00, 8'($urandom), 8'hFF}, 3'b111);
        pulses = 0; pulses2 = 0;
        repeat (256) begin
            step(0, 0, 24'h0, 3'b111);
            if (ce[0]) pulses++;
            if (ce[2]) pulses2++;
        end
        check("count_0xff", 32'(pulses), 32'd255);
        check("count_0x00", 32'(pulses2), 32'd0);

        // Randomized traffic
        repeat (300) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 24'($urandom), 3'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
